// File: rtl/mult_share_arb_pkg.sv
// Shared types and constants for the shared-multiplier arbiter: operand and
// product widths, slot state encoding and the tagged response record.
package mult_share_arb_pkg;

    localparam int MULT_W   = 4;
    localparam int PROD_W   = 2 * MULT_W;
    localparam int ID_MAX_W = 3;   // wide enough for the largest legal N_REQ (8)
    localparam int CNT_W    = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [PROD_W-1:0]   product;
    } rsp_t;

endpackage : mult_share_arb_pkg

// File: rtl/mult_share_arb_mult.sv
// Combinational 4x4 unsigned array multiplier: shifted AND partial-product rows
// summed by a ripple adder chain, one row per multiplier bit.
module array_mult4x4
    import mult_share_arb_pkg::*;
(
    input  logic [MULT_W-1:0] a,
    input  logic [MULT_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] acc;

    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every output a default first, so no latch is inferred.
        acc = '0;
        for (int i = 0; i < MULT_W; i++) begin
            acc = acc + (PROD_W'(a & {MULT_W{b[i]}}) << i);
        end
        p = acc;
    end

endmodule : array_mult4x4

// File: rtl/mult_share_arb_rr_grant.sv
// N_REQ-wide round-robin picker: scans from last_grant+1 (mod N_REQ) and
// returns the first requesting index as both one-hot and binary.
module rr_grant #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             any
);

    int idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = 0;
        // Offset N_REQ wraps back to last_grant itself, so it is searched last.
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(last_grant) + off) % N_REQ;
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = ID_W'(idx);
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule : rr_grant

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one 4x4 multiplier among N_REQ requesters, with a
// single-entry tagged result slot, valid/ready drain and saturating op counter.
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [MULT_W*N_REQ-1:0]  req_a,
    input  logic [MULT_W*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [PROD_W-1:0]        rsp_product,
    input  logic                     rsp_ready,
    output logic [CNT_W-1:0]         op_count
);

    slot_state_t       state;
    rsp_t              slot;
    logic [ID_W-1:0]   last_grant;

    logic [N_REQ-1:0]  gnt_onehot;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              can_accept;
    logic              accept;
    logic [MULT_W-1:0] op_a;
    logic [MULT_W-1:0] op_b;
    logic [PROD_W-1:0] product;

    rr_grant #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_grant (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    // A full slot may take a new pair only when it is being drained this cycle.
    assign can_accept = (state == SLOT_EMPTY) || rsp_ready;
    assign accept     = can_accept && gnt_any && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready = gnt_onehot;
        end
    end

    assign op_a = req_a[int'(gnt_idx)*MULT_W +: MULT_W];
    assign op_b = req_b[int'(gnt_idx)*MULT_W +: MULT_W];

    array_mult4x4 u_mult (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    always_ff @(posedge clk) begin
        // NOTE: registers are written with non-blocking '<=' so every flop samples pre-edge values.
        if (rst) begin
            state      <= SLOT_EMPTY;
            slot       <= '0;
            last_grant <= ID_W'(N_REQ - 1);
            op_count   <= '0;
        end else begin
            if (accept) begin
                slot.id      <= ID_MAX_W'(gnt_idx);
                slot.product <= product;
                last_grant   <= gnt_idx;
                state        <= SLOT_FULL;
            end else if (rsp_ready) begin
                state <= SLOT_EMPTY;
            end

            if ((state == SLOT_FULL) && rsp_ready && (op_count != '1)) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

    assign rsp_valid   = (state == SLOT_FULL);
    assign rsp_id      = slot.id[ID_W-1:0];
    assign rsp_product = slot.product;

endmodule : mult_share_arb

// File: tb/tb_mult_share_arb.sv
// Directed self-checking bench for mult_share_arb with a reference grant model
// and a queue scoreboard of expected {id, product} responses.
module tb_mult_share_arb;

    localparam int N = 4;

    typedef struct {
        logic [1:0] id;
        logic [7:0] prod;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [4*N-1:0] req_a;
    logic [4*N-1:0] req_b;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [7:0]    rsp_product;
    logic          rsp_ready;
    logic [15:0]   op_count;

    int n_assert = 0;
    int n_fail   = 0;

    exp_t        sb[$];
    logic        mdl_full;
    int          mdl_last;
    logic [15:0] mdl_cnt;

    always #5 clk = ~clk;

    mult_share_arb #(
        .N_REQ (N),
        .ID_W  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_ready   (rsp_ready),
        .op_count    (op_count)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    // One clock with model-based checks; inputs must already be driven.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        int           g;
        exp_t         e;
        logic [3:0]   a;
        logic [3:0]   b;
        #1;
        exp_ready = '0;
        g = -1;
        if (!mdl_full || rsp_ready) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && req_valid[(mdl_last + k) % N]) g = (mdl_last + k) % N;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 16'(req_ready), 16'(exp_ready));
        check("rsp_valid", 16'(rsp_valid), 16'(mdl_full));
        check("op_count", op_count, mdl_cnt);
        if (mdl_full) begin
            e = sb[0];
            check("rsp_id", 16'(rsp_id), 16'(e.id));
            check("rsp_product", 16'(rsp_product), 16'(e.prod));
            if (rsp_ready) begin
                void'(sb.pop_front());
                if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
            end
        end
        if (g >= 0) begin
            a = req_a[4*g +: 4];
            b = req_b[4*g +: 4];
            e.id   = 2'(g);
            e.prod = 8'(a) * 8'(b);
            sb.push_back(e);
            mdl_last = g;
            mdl_full = 1'b1;
        end else if (rsp_ready) begin
            mdl_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge with the given req_valid asserted, then check reset values.
    task automatic do_reset(input logic [N-1:0] valid_during);
        rst       = 1'b1;
        req_valid = valid_during;
        rsp_ready = 1'b1;
        #1;
        check("req_ready_in_reset", 16'(req_ready), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        check("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        check("rst_rsp_id", 16'(rsp_id), 16'h0);
        check("rst_rsp_product", 16'(rsp_product), 16'h0);
        check("rst_op_count", op_count, 16'h0);
        sb.delete();
        mdl_full = 1'b0;
        mdl_last = N - 1;
        mdl_cnt  = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        mdl_full  = 1'b0;
        mdl_last  = N - 1;
        mdl_cnt   = '0;

        // Reset with all requesters valid: no grant may leak out.
        do_reset('1);

        // Single request from requester 2: 13*11 = 143.
        set_lane(2, 4'd13, 4'd11);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        check("single_req_ready", 16'(req_ready), 16'b0100);
        cycle();
        req_valid = '0;
        check("single_rsp_valid", 16'(rsp_valid), 16'h1);
        check("single_rsp_id", 16'(rsp_id), 16'd2);
        check("single_rsp_product", 16'(rsp_product), 16'd143);
        cycle();
        check("single_op_count", op_count, 16'd1);
        check("single_drained", 16'(rsp_valid), 16'h0);

        // All four valid continuously: grants 0,1,2,3 repeating, one per cycle.
        do_reset('0);
        for (int i = 0; i < N; i++) set_lane(i, 4'(i + 1), 4'd15);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            check("rr_id", 16'(rsp_id), 16'(k % N));
            check("rr_product", 16'(rsp_product), 16'(15 * ((k % N) + 1)));
        end
        req_valid = '0;
        cycle();
        cycle();
        check("rr_op_count", op_count, 16'd12);

        // Backpressure: 15*15 held for 5 cycles with everyone requesting.
        do_reset('0);
        set_lane(0, 4'd15, 4'd15);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        cycle();
        req_valid = '1;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_req_ready", 16'(req_ready), 16'h0);
            check("bp_product", 16'(rsp_product), 16'd225);
            check("bp_id", 16'(rsp_id), 16'd0);
            cycle();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        cycle();
        check("bp_drained", 16'(rsp_valid), 16'h0);
        check("bp_op_count", op_count, 16'd1);

        // Drain-and-refill in one cycle: id 1 leaves while requester 3 (0*9) loads.
        do_reset('0);
        set_lane(1, 4'd3, 4'd5);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        cycle();
        set_lane(3, 4'd0, 4'd9);
        req_valid = 4'b1000;
        cycle();
        check("refill_valid", 16'(rsp_valid), 16'h1);
        check("refill_id", 16'(rsp_id), 16'd3);
        check("refill_product", 16'(rsp_product), 16'd0);

        // Reset while full with id 1, product 42.
        set_lane(1, 4'd6, 4'd7);
        req_valid = 4'b0010;
        cycle();
        check("prerst_id", 16'(rsp_id), 16'd1);
        check("prerst_product", 16'(rsp_product), 16'd42);
        check("prerst_op_count", op_count, 16'd2);
        do_reset('1);
        req_valid = '1;
        #1;
        check("postrst_first_grant", 16'(req_ready), 16'b0001);
        cycle();
        req_valid = '0;
        cycle();

        // Saturation of op_count after more than 65535 handshakes.
        do_reset('0);
        set_lane(0, 4'd1, 4'd1);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        for (int k = 0; k < 65540; k++) cycle();
        check("sat_op_count", op_count, 16'hFFFF);
        for (int k = 0; k < 4; k++) cycle();
        check("sat_op_count_hold", op_count, 16'hFFFF);
        req_valid = '0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_mult_share_arb
